fa_ha: RTL and testbench
========================

Name: fa_ha

Overview:
- 1-bit arithmetic leaf block containing one half adder (a+b) and one full adder (a+b+cin), both fed by shared operand inputs.
- Adder cores are purely combinational.
- A registered output stage with a valid qualifier lets the block sit directly in a clocked datapath (e.g. a partial-product reduction stage of the matrix multiplier).
- A parameter bypasses the register stage for purely combinational use.

Parameters:
- REG_OUT, 1, 1 = outputs registered (latency 1 clk); 0 = outputs combinational (latency 0, clk/rst_n unused except out_valid).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b/cin valid this cycle
- a  input  1  operand A (shared by HA and FA)
- b  input  1  operand B (shared by HA and FA)
- cin  input  1  carry-in, FA only; ignored by HA
- ha_sum  output  1  half-adder sum = a XOR b
- ha_cout  output  1  half-adder carry = a AND b
- fa_sum  output  1  full-adder sum = a XOR b XOR cin
- fa_cout  output  1  full-adder carry = majority(a,b,cin)
- out_valid  output  1  outputs correspond to an accepted operand set

Behaviour:
- Arithmetic:
  - {ha_cout,ha_sum} = a + b (2-bit result, no overflow possible).
  - {fa_cout,fa_sum} = a + b + cin (2-bit result, max 2'b11).
- Internal structure:
  - Combinational HA core: sum = a^b, cout = a&b.
  - FA core built from two HA cores plus OR: s1 = a^b, c1 = a&b; fa_sum = s1^cin; fa_cout = c1 | (s1&cin).
- REG_OUT=1:
  - On rising clk with in_valid=1: capture all four results; out_valid<=1 next cycle.
  - On rising clk with in_valid=0: result registers hold previous values; out_valid<=0.
  - Latency exactly 1 clk from the in_valid edge to out_valid/results.
  - Back-to-back in_valid every cycle is supported; throughput is 1 result per clk.
- REG_OUT=0:
  - Outputs follow inputs combinationally, with no storage.
  - out_valid = in_valid.
  - Results are driven regardless of in_valid.
- Reset (REG_OUT=1):
  - rst_n low asynchronously forces ha_sum, ha_cout, fa_sum, fa_cout, out_valid to 0 immediately, without waiting for clk.
  - Deassertion is synchronous to clk by the system; the first capture occurs on the first rising edge with rst_n=1 and in_valid=1.
  - Reset mid-stream discards any pending result; no output glitches to stale data after release.
- X/Z on inputs while in_valid=0 must not corrupt held outputs.
- HA outputs never depend on cin.
- No handshake backpressure: the consumer must accept every out_valid pulse.

Test Plan:
- Exhaustive sweep, REG_OUT=1, in_valid=1 each cycle, {a,b,cin}=0..7 in order. One cycle later, expected HA {cout,sum}: 00,00,01,01,01,01,10,10. Expected FA {cout,sum}: 00,01,01,10,01,10,10,11. out_valid=1 throughout.
- Hold check: apply {a,b,cin}=3'b111 with in_valid=1, then toggle inputs with in_valid=0 for 3 cycles -> outputs stay ha=10, fa=11 and out_valid=0 after the first cycle.
- Async reset: with outputs at fa=11, assert rst_n=0 between clk edges -> all outputs 0 before the next edge. Release, then apply 3'b011 -> ha=01, fa=10 one cycle later.
- cin isolation: a=1, b=0, cin toggling 0/1 -> ha stays {0,1}; fa alternates {0,1}/{1,0}.
- REG_OUT=0: sweep 0..7 with 1 ns settle each step -> same values as the first scenario with zero clock latency; out_valid mirrors in_valid.

Source files
------------

// File: rtl/fa_ha.sv
// fa_ha: 1-bit half adder and full adder on shared operands, with optional registered output stage
module fa_ha #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic ha_sum,
    output logic ha_cout,
    output logic fa_sum,
    output logic fa_cout,
    output logic out_valid
);
    logic w_s1;
    logic w_c1;
    logic w_fa_sum;
    logic w_fa_cout;

    // first half adder is also the standalone HA; the second folds in cin
    assign w_s1      = a ^ b;
    assign w_c1      = a & b;
    assign w_fa_sum  = w_s1 ^ cin;
    assign w_fa_cout = w_c1 | (w_s1 & cin);

    generate
        if (REG_OUT) begin : g_reg
            logic r_ha_sum;
            logic r_ha_cout;
            logic r_fa_sum;
            logic r_fa_cout;
            logic r_valid;
            // capture results only on accepted operands so idle inputs never disturb held data
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ha_sum  <= 1'b0;
                    r_ha_cout <= 1'b0;
                    r_fa_sum  <= 1'b0;
                    r_fa_cout <= 1'b0;
                    r_valid   <= 1'b0;
                end else begin
                    r_valid <= in_valid;
                    if (in_valid) begin
                        r_ha_sum  <= w_s1;
                        r_ha_cout <= w_c1;
                        r_fa_sum  <= w_fa_sum;
                        r_fa_cout <= w_fa_cout;
                    end
                end
            end
            assign ha_sum    = r_ha_sum;
            assign ha_cout   = r_ha_cout;
            assign fa_sum    = r_fa_sum;
            assign fa_cout   = r_fa_cout;
            assign out_valid = r_valid;
        end else begin : g_comb
            assign ha_sum    = w_s1;
            assign ha_cout   = w_c1;
            assign fa_sum    = w_fa_sum;
            assign fa_cout   = w_fa_cout;
            assign out_valid = in_valid;
        end
    endgenerate
endmodule

// File: tb/tb_fa_ha.sv
// tb_fa_ha: scoreboard bench for registered and combinational fa_ha variants
module tb_fa_ha;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic cin = 1'b0;
    logic r_ha_sum, r_ha_cout, r_fa_sum, r_fa_cout, r_out_valid;
    logic c_ha_sum, c_ha_cout, c_fa_sum, c_fa_cout, c_out_valid;
    logic [3:0] q[$];
    logic [3:0] last_exp = 4'b0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fa_ha #(.REG_OUT(1'b1)) u_reg (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .ha_sum(r_ha_sum), .ha_cout(r_ha_cout), .fa_sum(r_fa_sum), .fa_cout(r_fa_cout),
        .out_valid(r_out_valid)
    );

    fa_ha #(.REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .ha_sum(c_ha_sum), .ha_cout(c_ha_cout), .fa_sum(c_fa_sum), .fa_cout(c_fa_cout),
        .out_valid(c_out_valid)
    );

    // reference: {ha_cout,ha_sum,fa_cout,fa_sum} from plain integer addition
    function automatic logic [3:0] model(input logic [2:0] x);
        int ha;
        int fa;
        ha = int'(x[2]) + int'(x[1]);
        fa = ha + int'(x[0]);
        return {ha[1:0], fa[1:0]};
    endfunction

    function automatic void chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endfunction

    task automatic drive(input logic v, input logic [2:0] x);
        @(negedge clk);
        in_valid = v;
        {a, b, cin} = x;
        if (v) q.push_back(model(x));
    endtask

    // monitor: check registered outputs against scoreboard and combinational outputs against the live model
    always @(posedge clk or negedge rst_n) begin
        #1;
        if (!rst_n) begin
            q.delete();
            last_exp = 4'b0;
            chk("reset_out", {r_ha_cout, r_ha_sum, r_fa_cout, r_fa_sum}, 4'b0);
            chk("reset_valid", {3'b0, r_out_valid}, 4'b0);
        end else begin
            chk("out_valid", {3'b0, r_out_valid}, {3'b0, q.size() != 0});
            if (r_out_valid && q.size() != 0) last_exp = q.pop_front();
            chk("reg_result", {r_ha_cout, r_ha_sum, r_fa_cout, r_fa_sum}, last_exp);
        end
        chk("comb_result", {c_ha_cout, c_ha_sum, c_fa_cout, c_fa_sum}, model({a, b, cin}));
        chk("comb_valid", {3'b0, c_out_valid}, {3'b0, in_valid});
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b1, 3'(i));
        drive(1'b1, 3'b111);
        for (int i = 0; i < 3; i++) drive(1'b0, 3'(i * 3 + 2));
        drive(1'b1, 3'b111);
        drive(1'b0, 3'b000);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        {a, b, cin} = 3'b011;
        q.push_back(model(3'b011));
        for (int i = 0; i < 4; i++) drive(1'b1, {2'b10, 1'(i)});
        for (int i = 0; i < 40; i++) drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        repeat (3) drive(1'b0, 3'b000);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
